// File: rtl/timer_sched_pkg.sv
// Shared types and default parameter values for the timer_sched block.
// Arbitration policy is selected in timer_sched by TIMER_SCHED_RR_EN.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DefNReq  = 4;
    localparam int unsigned DefCntW  = 32;
    localparam int unsigned DefPresc = 32'd50_000;

endpackage

// File: rtl/tick_div.sv
// Prescaler: counts 0..PRESC while enabled and pulses tick_o on the PRESC cycle.
module tick_div
    import timer_sched_pkg::*;
#(
    parameter int unsigned PRESC = DefPresc
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    logic [31:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == PRESC);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Shared delay timer granted to one of N_REQ requesters at a time.
// Define TIMER_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned CNT_W = DefCntW,
    parameter int unsigned PRESC = DefPresc
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*CNT_W-1:0]   delay_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic [N_REQ-1:0]         done_o,
    output logic                     busy_o,
    output logic [$clog2(N_REQ)-1:0] owner_o
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [IdxW-1:0]   win;
    logic              win_vld;
    logic              grant;
    logic              run;
    logic              tick;

`ifdef TIMER_SCHED_RR_EN
    logic [IdxW-1:0] ptr_q, ptr_d;
    int              dist;
    int              best;

    // Winner is the requester at the smallest circular distance after ptr_q.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        best    = int'(N_REQ);
        dist    = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            dist = (k + 2 * int'(N_REQ) - int'(ptr_q) - 1) % int'(N_REQ);
            if (req_i[k] && (dist < best)) begin
                best    = dist;
                win     = IdxW'(k);
                win_vld = 1'b1;
            end
        end
    end

    assign ptr_d = (state_q == StDone) ? owner_q : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IdxW'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                win     = IdxW'(k);
                win_vld = 1'b1;
            end
        end
    end
`endif

    assign grant = (state_q == StIdle) && win_vld;
    assign run   = (state_q == StRun);

    tick_div #(
        .PRESC (PRESC)
    ) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (grant),
        .en_i   (run),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ack_d   = '0;
        case (state_q)
            StIdle: begin
                if (win_vld) begin
                    state_d    = StRun;
                    ack_d[win] = 1'b1;
                    cnt_d      = delay_i[win*CNT_W +: CNT_W];
                    owner_d    = win;
                end
            end
            StRun: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        done_o = '0;
        if (state_q == StDone) begin
            done_o[owner_q] = 1'b1;
        end
    end

    assign ack_o   = ack_q;
    assign busy_o  = (state_q != StIdle);
    assign owner_o = owner_q;

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The module SHALL have parameter CNT_W, default 32, meaning the width of the delay counter in ticks.
REQ-003 The module SHALL have parameter PRESC, default 32'd50_000, meaning the tick period is PRESC+1 clk cycles (PRESC >= 1).
REQ-004 clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-005 rst  input  1  is the reset; it is asynchronous and active-high.
REQ-006 req_i  input  N_REQ  carries one request level per requester.
REQ-007 delay_i  input  N_REQ*CNT_W  carries the requested delay in ticks; requester k uses slice [k*CNT_W +: CNT_W].
REQ-008 ack_o  output  N_REQ  carries a one-cycle grant pulse, one-hot.
REQ-009 done_o  output  N_REQ  carries a one-cycle expiry pulse, one-hot.
REQ-010 busy_o  output  1  SHALL be high whenever the shared timer is not in IDLE.
REQ-011 owner_o  output  $clog2(N_REQ)  carries the index of the current or last grantee.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, RUN, DONE.
- IDLE -> RUN: any req_i bit is high.
- RUN -> DONE: the count is 0.
- DONE -> IDLE: unconditionally, after one cycle.
REQ-013 On the IDLE->RUN edge, the block SHALL do all of the following:
- pick winner w per REQ-024;
- register ack_o[w]=1 for the first RUN cycle only;
- latch delay_i slice w into the count;
- set owner_o=w;
- clear the prescaler to 0.
REQ-014 In RUN, the prescaler SHALL count 0..PRESC; at PRESC it SHALL emit a tick and wrap to 0.
REQ-015 On a tick in RUN with a nonzero count, the count SHALL decrement by 1; the count SHALL never wrap below 0.
REQ-016 The cycle timing SHALL be as follows:
- request first seen in IDLE at cycle 0;
- ack_o high at cycle 1;
- done_o[w] high at cycle D*(PRESC+1)+2;
- IDLE again the following cycle.
REQ-017 A delay of D=0 SHALL give done_o at cycle 2, with no tick consumed.
REQ-018 In DONE, done_o[owner] SHALL be high for exactly one cycle, and the round-robin pointer SHALL be updated to owner_o.
REQ-019 req_i SHALL be ignored in RUN and DONE. Dropping req mid-RUN SHALL NOT cancel the timer. A req still high in IDLE after DONE SHALL count as a new request.
REQ-020 Requesters SHALL hold delay_i stable while req_i is high, until ack_o; the block samples delay_i only on the grant edge.

Reset
REQ-021 Asserting rst in any state, including mid-RUN, SHALL immediately force the following:
- FSM=IDLE, ack_o=0, done_o=0, busy_o=0, owner_o=0;
- prescaler=0, count=0;
- round-robin pointer=N_REQ-1, so that index 0 wins first.
REQ-022 No done_o pulse SHALL be produced for a grant interrupted by reset.
REQ-023 After rst deasserts, the first grant SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-024 The macro TIMER_SCHED_RR_EN SHALL select the arbitration policy:
- defined: round-robin; search starts at pointer+1 modulo N_REQ;
- undefined: fixed priority; lowest asserted index wins, and the pointer is unused.
The port list SHALL be identical in both builds.

Structure
REQ-025 Package timer_sched_pkg SHALL hold the following:
- the state enum typedef (IDLE/RUN/DONE);
- default constants for N_REQ, CNT_W, PRESC.
REQ-026 The prescaler SHALL be sub-module tick_div. It has a synchronous clear input and a one-cycle tick output, and it counts only while enabled (state==RUN).
REQ-027 Arbitration SHALL be combinational logic inside timer_sched; no further sub-modules.

Verification
All scenarios use PRESC=3 and N_REQ=4.
REQ-028 Scenario: reset, then req_i=4'b0001 with delay0=2 at cycle 0. Required response:
- ack_o=0001 at cycle 1;
- done_o=0001 at cycle 10;
- busy_o high for cycles 1..10.
REQ-029 Scenario: req_i=4'b0100 with delay2=0. Required response: ack_o at cycle 1, done_o=0100 at cycle 2, no tick observed.
REQ-030 Scenario: req_i=4'b1111 held with all delays 1. Required grant order:
- with TIMER_SCHED_RR_EN: 0,1,2,3,0;
- without it: 0,0,0.
REQ-031 Scenario: rst pulsed mid-RUN at cycle 5 of a delay=3 grant. Required response:
- all outputs 0 immediately;
- no done_o pulse;
- a subsequent req_i=0010 grants index 1, or index 0 if also requested.
REQ-032 Scenario: req0 granted, req0 dropped at cycle 3, req3 raised during RUN. Required response:
- done_o=0001 still occurs;
- ack_o=1000 occurs 2 cycles after done_o.
REQ-033 Scenario: delay0='1 (all ones) with PRESC=1. Required response: the count decrements monotonically from all-ones with no wrap observed; the bench aborts via rst after 1000 cycles.
